// File: rtl/logic_pkg.sv
// Shared definitions for the logic/shift pipeline.
//   op_e  : 3-bit opcode encoding of the logic/shift operations
//   sh_w(): width of the shift-amount field for a given operand width
package logic_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_NAND = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_SHL  = 3'b110,
    OP_SHR  = 3'b111
  } op_e;

  // Shift-amount width: enough bits to address every bit position of the operand.
  function automatic int sh_w(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/logic_shift_core.sv
// Combinational logic/shift function unit.
//   a_i      : operand A
//   b_i      : operand B; low sh_w(DATA_W) bits double as the shift amount
//   op_i     : operation select
//   result_o : DATA_W-bit result (shifted-out bits are dropped)
module logic_shift_core
  import logic_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  op_e               op_i,
  output logic [DATA_W-1:0] result_o
);

  localparam int SH_W = sh_w(DATA_W);

  logic [SH_W-1:0] sh_amt;
  assign sh_amt = b_i[SH_W-1:0];

  always_comb begin
    // NOTE: assign a default before the case so no path leaves result_o
    // unassigned; otherwise synthesis infers a latch.
    result_o = '0;
    unique case (op_i)
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_NAND: result_o = ~(a_i & b_i);
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_XOR:  result_o = a_i ^ b_i;
      OP_XNOR: result_o = ~(a_i ^ b_i);
      OP_SHL:  result_o = a_i << sh_amt;
      OP_SHR:  result_o = a_i >> sh_amt;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_shift_pipe.sv
// Two-stage pipelined logic/shift unit with valid/ready handshake on both
// sides, result flags and a saturating completed-transfer counter.
//   CLK, RST          : clock, synchronous active-high reset
//   A, B, ALU_FUN     : operands and opcode, qualified by in_valid
//   in_valid/in_ready : input handshake (in_ready has no path from in_valid)
//   out_data          : result, zero-extended to OUT_W
//   out_valid/out_ready : output handshake
//   zero_flag/par_flag  : out_data == 0 / XOR-reduce of out_data
//   op_count          : number of completed output transfers, saturating
module logic_shift_pipe
  import logic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [2:0]        ALU_FUN,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              zero_flag,
  output logic              par_flag,
  output logic [CNT_W-1:0]  op_count
);

  // Stage 1 registers
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d;
  logic [DATA_W-1:0] s1_b_q, s1_b_d;
  op_e               s1_op_q, s1_op_d;

  // Stage 2 (output) registers
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              zero_q, zero_d;
  logic              par_q, par_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  // Handshake
  logic s2_free;
  logic s1_adv;
  logic accept;
  logic xfer;

  logic [DATA_W-1:0] core_res;
  logic [OUT_W-1:0]  core_res_ext;

  assign s2_free  = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !RST && (!s1_valid_q || s2_free);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;

  logic_shift_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .op_i     (s1_op_q),
    .result_o (core_res)
  );

  assign core_res_ext = OUT_W'(core_res);

  // Stage 1: when in_ready is high, S1 is either empty or emptying this
  // cycle, so its next valid is simply whether a new op is offered.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (accept) begin
      s1_a_d  = A;
      s1_b_d  = B;
      s1_op_d = op_e'(ALU_FUN);
    end
  end

  // Stage 2: loads whenever the output is free; a transfer with nothing
  // advancing from S1 drops out_valid, data and flags hold their values.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    zero_d      = zero_q;
    par_d       = par_q;
    if (s2_free) begin
      out_valid_d = s1_valid_q;
    end
    if (s1_adv) begin
      out_data_d = core_res_ext;
      zero_d     = (core_res_ext == '0);
      par_d      = ^core_res_ext;
    end
  end

  always_comb begin
    op_count_d = op_count_q;
    if (xfer && (op_count_q != {CNT_W{1'b1}})) begin
      op_count_d = op_count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      zero_q      <= 1'b0;
      par_q       <= 1'b0;
      op_count_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      zero_q      <= zero_d;
      par_q       <= par_d;
      op_count_q  <= op_count_d;
    end
  end

  // NOTE: S1 operand registers are qualified by s1_valid_q, so they carry no
  // reset; this keeps reset off the wide datapath flops.
  always_ff @(posedge CLK) begin
    s1_a_q  <= s1_a_d;
    s1_b_q  <= s1_b_d;
    s1_op_q <= s1_op_d;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign zero_flag = zero_q;
  assign par_flag  = par_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_logic_shift_pipe.sv
// Self-checking bench for logic_shift_pipe (DATA_W=8, OUT_W=16, CNT_W=16).
// Accepted ops push their modelled result onto a queue; the monitor pops and
// compares on every observed output transfer.
module tb_logic_shift_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  A, B;
  logic [2:0]  ALU_FUN;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        zero_flag;
  logic        par_flag;
  logic [15:0] op_count;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int pops   = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc  = 0;

  logic [15:0] exp_q[$];

  logic_shift_pipe #(
    .DATA_W (8),
    .OUT_W  (16),
    .CNT_W  (16)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .ALU_FUN   (ALU_FUN),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .zero_flag (zero_flag),
    .par_flag  (par_flag),
    .op_count  (op_count)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    logic [7:0] r;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = ~(a & b);
      3'd3: r = ~(a | b);
      3'd4: r = a ^ b;
      3'd5: r = ~(a ^ b);
      3'd6: r = a << b[2:0];
      default: r = a >> b[2:0];
    endcase
    return {8'h00, r};
  endfunction

  // Monitor: a transfer happens at the next posedge when valid & ready.
  always @(negedge CLK) begin
    if (!RST && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", out_valid, 1'b0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("out_data", out_data, e);
        check("zero_flag", zero_flag, (e == 16'h0000));
        check("par_flag", par_flag, ^e);
        if (pops == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        pops++;
      end
    end
  end

  // Called in the posedge+1 phase; returns in the posedge+1 phase after acceptance.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int budget;
    budget   = 0;
    A        = a;
    B        = b;
    ALU_FUN  = op;
    in_valid = 1'b1;
    @(negedge CLK);
    while (!in_ready && budget < 40) begin
      budget++;
      @(negedge CLK);
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1'b1);
    end else begin
      exp_q.push_back(model(a, b, op));
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      budget++;
      @(posedge CLK);
      #1;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] first_exp;
    RST       = 1'b1;
    A         = 8'h00;
    B         = 8'h00;
    ALU_FUN   = 3'd0;
    in_valid  = 1'b1;
    out_ready = 1'b1;

    // 1. Reset with in_valid asserted
    repeat (2) begin
      @(negedge CLK);
      check("rst_in_ready", in_ready, 1'b0);
    end
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_zero", zero_flag, 1'b0);
    check("rst_par", par_flag, 1'b0);
    check("rst_op_count", op_count, 16'd0);
    @(posedge CLK);
    #1;
    RST      = 1'b0;
    in_valid = 1'b0;

    // 2. Single AND
    send(8'hF0, 8'h3C, 3'b000);
    drain();
    check("op_count_t2", op_count, 16'd1);

    // 3. Directed boundary ops
    send(8'hFF, 8'hFF, 3'b010);
    send(8'h81, 8'h03, 3'b110);
    send(8'h81, 8'h07, 3'b111);
    drain();
    check("op_count_t3", op_count, 16'd4);

    // 4. Back-pressure: two ops fill the pipe, third is refused
    do_reset();
    out_ready = 1'b0;
    first_exp = model(8'h5A, 8'h0F, 3'b100);
    send(8'h5A, 8'h0F, 3'b100);
    send(8'hC3, 8'h02, 3'b111);
    A        = 8'h0F;
    B        = 8'hF0;
    ALU_FUN  = 3'b011;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_out_data", out_data, first_exp);
    end
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    send(8'h0F, 8'hF0, 3'b011);
    drain();
    check("op_count_t4", op_count, 16'd3);

    // 5. Eight back-to-back random ops at full throughput
    do_reset();
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      send(8'($urandom_range(255)), 8'($urandom_range(255)), 3'($urandom_range(7)));
    end
    drain();
    check("t5_pops", pops, 8);
    check("t5_consecutive", last_pop_cyc - first_pop_cyc, 7);
    check("op_count_t5", op_count, 16'd8);

    // 6. Reset with both stages occupied
    out_ready = 1'b0;
    send(8'h12, 8'h34, 3'b001);
    send(8'h56, 8'h01, 3'b110);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_op_count", op_count, 16'd0);
    check("t6_in_ready", in_ready, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      check("t6_no_stale", out_valid, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
